bcd_counter_pio: RTL and testbench

BCD_COUNTER_PIO -- requirements
Module: bcd_counter_pio

---
 rtl/bcd_counter_pio_pkg.sv | 25 ++
 rtl/bcd_counter_pio_digit.sv | 35 +++
 rtl/bcd_counter_pio.sv | 124 ++++++++++++
 tb/tb_bcd_counter_pio.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/bcd_counter_pio_pkg.sv
// Shared constants for the BCD counter PIO: register offsets,
// CTRL/STATUS bit positions, digit width and a digit clamp helper.
package bcd_counter_pio_pkg;

  localparam int DIGIT_W = 4;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_CTRL   = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;
  localparam logic [1:0] ADDR_STEP   = 2'd3;

  localparam int CTRL_RUN    = 0;
  localparam int CTRL_DOWN   = 1;
  localparam int CTRL_IRQ_EN = 2;
  localparam int CTRL_W      = 3;

  localparam int STATUS_WRAP = 0;

  function automatic logic [DIGIT_W-1:0] clamp_digit(
    input logic [DIGIT_W-1:0] d
  );
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

endpackage

// File: rtl/bcd_counter_pio_digit.sv
// One BCD digit of the ripple chain.
// Ports: value (current digit), en, down -> next, carry (carry/borrow out).
module bcd_digit
  import bcd_counter_pio_pkg::*;
(
  input  logic [DIGIT_W-1:0] value,
  input  logic               en,
  input  logic               down,
  output logic [DIGIT_W-1:0] next,
  output logic               carry
);

  always_comb begin
    next  = value;
    carry = 1'b0;
    if (en) begin
      if (down) begin
        if (value == 4'd0) begin
          next  = 4'd9;
          carry = 1'b1;
        end else begin
          next = value - 4'd1;
        end
      end else begin
        if (value >= 4'd9) begin
          next  = 4'd0;
          carry = 1'b1;
        end else begin
          next = value + 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/bcd_counter_pio.sv
// Avalon-MM BCD up/down counter with prescaled tick, STEP and wrap irq.
// Ports: clk, reset_n, address/chipselect/write_n/writedata/readdata,
// out_port (BCD value, digit 0 in [3:0]), irq (WRAP & IRQ_EN).
module bcd_counter_pio
  import bcd_counter_pio_pkg::*;
#(
  parameter int N_DIGITS = 3,
  parameter int PRESCALE = 50000000
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [1:0]                  address,
  input  logic                        chipselect,
  input  logic                        write_n,
  input  logic [31:0]                 writedata,
  output logic [31:0]                 readdata,
  output logic [DIGIT_W*N_DIGITS-1:0] out_port,
  output logic                        irq
);

  localparam int DW = DIGIT_W * N_DIGITS;
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

  logic [DW-1:0]     data_q;
  logic [CTRL_W-1:0] ctrl_q;
  logic              wrap_q;
  logic [PW-1:0]     presc_q;

  logic              wr;
  logic              data_wr;
  logic              ctrl_wr;
  logic              status_wr;
  logic              step_wr;
  logic              run;
  logic              tick;
  logic              step;
  logic              wrap_step;
  logic [DW-1:0]     next_val;
  logic [DW-1:0]     clamped;
  logic [N_DIGITS:0] en;
  logic              unused_wd;

  assign wr        = chipselect & ~write_n;
  assign data_wr   = wr && (address == ADDR_DATA);
  assign ctrl_wr   = wr && (address == ADDR_CTRL);
  assign status_wr = wr && (address == ADDR_STATUS);
  assign step_wr   = wr && (address == ADDR_STEP);
  assign unused_wd = ^writedata;

  assign run  = ctrl_q[CTRL_RUN];
  assign tick = run && (presc_q == PMAX);
  // tick and STEP collapse into a single step
  assign step = tick | step_wr;

  assign en[0]     = step;
  assign wrap_step = en[N_DIGITS];

  for (genvar g = 0; g < N_DIGITS; g++) begin : g_dig
    bcd_digit u_digit (
      .value (data_q[g*DIGIT_W +: DIGIT_W]),
      .en    (en[g]),
      .down  (ctrl_q[CTRL_DOWN]),
      .next  (next_val[g*DIGIT_W +: DIGIT_W]),
      .carry (en[g+1])
    );
    assign clamped[g*DIGIT_W +: DIGIT_W] =
      clamp_digit(writedata[g*DIGIT_W +: DIGIT_W]);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc_q <= '0;
    end else if (!run || tick) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + 1'b1;
    end
  end

  // a DATA write overrides any same-cycle step
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q <= '0;
    end else if (data_wr) begin
      data_q <= clamped;
    end else if (step) begin
      data_q <= next_val;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_q <= '0;
    end else if (ctrl_wr) begin
      ctrl_q <= writedata[CTRL_W-1:0];
    end
  end

  // a wrap setting WRAP beats a same-cycle W1C
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wrap_q <= 1'b0;
    end else if (wrap_step && !data_wr) begin
      wrap_q <= 1'b1;
    end else if (status_wr && writedata[STATUS_WRAP]) begin
      wrap_q <= 1'b0;
    end
  end

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_DATA:   readdata[DW-1:0]     = data_q;
      ADDR_CTRL:   readdata[CTRL_W-1:0] = ctrl_q;
      ADDR_STATUS: readdata[STATUS_WRAP] = wrap_q;
      default:     readdata = '0;
    endcase
  end

  assign out_port = data_q;
  assign irq      = wrap_q & ctrl_q[CTRL_IRQ_EN];

endmodule

// File: tb/tb_bcd_counter_pio.sv
// Self-checking bench for bcd_counter_pio (N_DIGITS=3, PRESCALE=4).
// Ports: none; drives the DUT over its Avalon-MM slave interface.
module tb_bcd_counter_pio;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [11:0] out_port;
  logic        irq;

  int checks;
  int errors;

  bcd_counter_pio #(
    .N_DIGITS (3),
    .PRESCALE (4)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .out_port   (out_port),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] wdata;
    logic [11:0] exp;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(posedge clk);
    #1;
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    #1;
    d          = readdata;
    chipselect = 1'b0;
  endtask

  logic [31:0] r;

  initial begin
    checks     = 0;
    errors     = 0;
    reset_n    = 1'b0;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;

    vecs[0] = '{32'h0000_00F9, 12'h099};
    vecs[1] = '{32'h0000_0123, 12'h123};
    vecs[2] = '{32'h0000_0FFF, 12'h999};
    vecs[3] = '{32'h0000_0A5B, 12'h959};
    vecs[4] = '{32'hFFFF_F456, 12'h456};
    vecs[5] = '{32'h0000_0000, 12'h000};

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    for (int a = 0; a < 4; a++) begin
      rd(2'(a), r);
      check($sformatf("reset_read_%0d", a), r, 32'h0);
    end
    check("reset_out", {20'h0, out_port}, 32'h0);
    check("reset_irq", {31'h0, irq}, 32'h0);

    for (int i = 0; i < 6; i++) begin
      wr(2'd0, vecs[i].wdata);
      check($sformatf("vec%0d_out", i), {20'h0, out_port},
            {20'h0, vecs[i].exp});
      rd(2'd0, r);
      check($sformatf("vec%0d_rd", i), r, {20'h0, vecs[i].exp});
    end

    // STEP reads zero
    rd(2'd3, r);
    check("step_reads0", r, 32'h0);

    // Down steps via STEP with borrow and wrap
    wr(2'd0, 32'h100);
    wr(2'd1, 32'h2);
    rd(2'd1, r);
    check("ctrl_rd", r, 32'h2);
    wr(2'd3, 32'h1);
    check("down_borrow", {20'h0, out_port}, 32'h099);
    rd(2'd2, r);
    check("down_nowrap", r, 32'h0);
    wr(2'd0, 32'h000);
    wr(2'd3, 32'h1);
    check("down_wrap_out", {20'h0, out_port}, 32'h999);
    rd(2'd2, r);
    check("down_wrap_flag", r, 32'h1);
    check("irq_masked", {31'h0, irq}, 32'h0);
    wr(2'd2, 32'h1);
    rd(2'd2, r);
    check("w1c_clear", r, 32'h0);

    // Up step carry through two digits
    wr(2'd1, 32'h0);
    wr(2'd0, 32'h199);
    wr(2'd3, 32'h1);
    check("up_carry", {20'h0, out_port}, 32'h200);

    // Running up count wraps and raises irq
    wr(2'd0, 32'h998);
    wr(2'd1, 32'h5);
    repeat (3) @(posedge clk);
    #1;
    check("run_no_early", {20'h0, out_port}, 32'h998);
    @(posedge clk);
    #1;
    check("run_tick1", {20'h0, out_port}, 32'h999);
    repeat (4) @(posedge clk);
    #1;
    check("run_wrap_out", {20'h0, out_port}, 32'h000);
    check("run_irq", {31'h0, irq}, 32'h1);
    rd(2'd2, r);
    check("run_wrap_flag", r, 32'h1);
    wr(2'd2, 32'h1);
    check("irq_cleared", {31'h0, irq}, 32'h0);

    // WRAP set on a tick beats same-cycle W1C
    wr(2'd1, 32'h0);
    wr(2'd0, 32'h999);
    wr(2'd1, 32'h1);
    repeat (3) @(posedge clk);
    wr(2'd2, 32'h1);
    check("w1c_race_out", {20'h0, out_port}, 32'h000);
    rd(2'd2, r);
    check("w1c_race_wrap", r, 32'h1);

    // DATA write on tick cycle wins and leaves WRAP alone
    wr(2'd1, 32'h0);
    wr(2'd2, 32'h1);
    wr(2'd0, 32'h999);
    wr(2'd1, 32'h1);
    repeat (3) @(posedge clk);
    wr(2'd0, 32'h500);
    check("data_win_out", {20'h0, out_port}, 32'h500);
    repeat (3) @(posedge clk);
    #1;
    check("data_win_hold", {20'h0, out_port}, 32'h500);
    @(posedge clk);
    #1;
    check("data_win_next", {20'h0, out_port}, 32'h501);
    rd(2'd2, r);
    check("data_win_nowrap", r, 32'h0);

    // Reset mid-count
    wr(2'd1, 32'h0);
    wr(2'd0, 32'h123);
    wr(2'd1, 32'h1);
    repeat (2) @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    check("rst_async_out", {20'h0, out_port}, 32'h000);
    check("rst_async_irq", {31'h0, irq}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("rst_no_count", {20'h0, out_port}, 32'h000);
    rd(2'd1, r);
    check("rst_ctrl", r, 32'h0);
    wr(2'd1, 32'h1);
    repeat (4) @(posedge clk);
    #1;
    check("rst_resume", {20'h0, out_port}, 32'h001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
